// File: rtl/stopwatch_sampler.sv
// stopwatch_sampler: debounced run/lap/clear buttons, two-digit BCD seconds
// counter, and lap sampling for the downstream sample stash.
// Optional feature macro: SAMPLE_ON_PAUSE_EN (RUN -> PAUSE also emits a sample).
module stopwatch_sampler #(
    parameter int unsigned TICK_CYCLES     = 100_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_run,
    input  logic       btn_lap,
    input  logic       btn_clr,
    output logic [7:0] count_bcd,
    output logic       running,
    output logic [7:0] sample_out,
    output logic       sample_valid
);

    localparam int unsigned TICK_W  = $clog2(TICK_CYCLES);
    localparam int unsigned DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned BTN_RUN = 0;
    localparam int unsigned BTN_LAP = 1;
    localparam int unsigned BTN_CLR = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    logic [2:0]            sync1_q, sync1_d;
    logic [2:0]            sync2_q, sync2_d;
    logic [2:0]            level_q, level_d;
    logic [2:0]            level_prev_q, level_prev_d;
    logic [2:0][DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [2:0]            press_c;

    state_t                state_q, state_d;
    logic [TICK_W-1:0]     presc_q, presc_d;
    logic [7:0]            count_q, count_d;
    logic [7:0]            sample_q, sample_d;
    logic                  sample_valid_q, sample_valid_d;
    logic                  running_q, running_d;
    logic                  tick_c;

    // Button front end: synchronize, debounce, and edge-detect accepted presses
    always_comb begin
        sync1_d      = {btn_clr, btn_lap, btn_run};
        sync2_d      = sync1_q;
        level_d      = level_q;
        level_prev_d = level_q;
        deb_cnt_d    = '0;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != level_q[i]) begin
                if (deb_cnt_q[i] == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                    level_d[i] = ~level_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
                end
            end
        end
        press_c = level_q & ~level_prev_q;
    end

    // Control FSM, prescaler, BCD counter and lap sampling
    always_comb begin
        state_d        = state_q;
        presc_d        = presc_q;
        count_d        = count_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        tick_c         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                presc_d = '0;
                if (press_c[BTN_RUN]) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (presc_q == TICK_W'(TICK_CYCLES - 1)) begin
                    tick_c  = 1'b1;
                    presc_d = '0;
                end else begin
                    presc_d = presc_q + TICK_W'(1);
                end
                if (press_c[BTN_RUN]) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                // Run beats clear when both arrive together
                if (press_c[BTN_RUN]) begin
                    state_d = ST_RUN;
                end else if (press_c[BTN_CLR]) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    presc_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (tick_c) begin
            if (count_q[3:0] == 4'd9) begin
                count_d[3:0] = 4'd0;
                count_d[7:4] = (count_q[7:4] == 4'd9) ? 4'd0 : count_q[7:4] + 4'd1;
            end else begin
                count_d[3:0] = count_q[3:0] + 4'd1;
            end
        end

        // Sample the pre-tick count so a coincident tick is not seen
        if (press_c[BTN_LAP] && (state_q != ST_IDLE)) begin
            sample_d       = count_q;
            sample_valid_d = 1'b1;
        end
`ifdef SAMPLE_ON_PAUSE_EN
        if (press_c[BTN_RUN] && (state_q == ST_RUN)) begin
            sample_d       = count_q;
            sample_valid_d = 1'b1;
        end
`endif

        running_d = (state_d == ST_RUN);
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            level_q        <= '0;
            level_prev_q   <= '0;
            deb_cnt_q      <= '0;
            state_q        <= ST_IDLE;
            presc_q        <= '0;
            count_q        <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            running_q      <= 1'b0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            level_q        <= level_d;
            level_prev_q   <= level_prev_d;
            deb_cnt_q      <= deb_cnt_d;
            state_q        <= state_d;
            presc_q        <= presc_d;
            count_q        <= count_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            running_q      <= running_d;
        end
    end

    assign count_bcd    = count_q;
    assign running      = running_q;
    assign sample_out   = sample_q;
    assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_stopwatch_sampler.sv
// Directed bench for stopwatch_sampler with a sample scoreboard.
module tb_stopwatch_sampler;

    logic       clk;
    logic       reset;
    logic       btn_run;
    logic       btn_lap;
    logic       btn_clr;
    logic [7:0] count_bcd;
    logic       running;
    logic [7:0] sample_out;
    logic       sample_valid;

    int         checks;
    int         errors;
    logic [7:0] exp_q[$];

    logic [7:0] prev_count;
    bit         seen_09_10;
    bit         seen_99_00;
    bit         bad_nibble;

    stopwatch_sampler #(
        .TICK_CYCLES    (10),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_run     (btn_run),
        .btn_lap     (btn_lap),
        .btn_clr     (btn_clr),
        .count_bcd   (count_bcd),
        .running     (running),
        .sample_out  (sample_out),
        .sample_valid(sample_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_count(input logic [7:0] v, input int bound, input string name);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < bound; n++) begin
            step();
            if (count_bcd == v) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s: count %h never reached %h within %0d cycles", name, count_bcd, v, bound);
        end
    endtask

    task automatic wait_running(input logic v, input int bound, input string name);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < bound; n++) begin
            step();
            if (running == v) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s: running %b never became %b within %0d cycles", name, running, v, bound);
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest expected sample
    always @(negedge clk) begin
        if (reset === 1'b1 && sample_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_sample: got %h expected no sample at %0t", sample_out, $time);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (sample_out !== e) begin
                    errors++;
                    $display("FAIL sample: got %h expected %h at %0t", sample_out, e, $time);
                end
            end
        end
    end

    // Count tracker: BCD legality and the two carry transitions
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (count_bcd[3:0] > 4'd9 || count_bcd[7:4] > 4'd9) bad_nibble = 1'b1;
            if (prev_count == 8'h09 && count_bcd == 8'h10) seen_09_10 = 1'b1;
            if (prev_count == 8'h99 && count_bcd == 8'h00) seen_99_00 = 1'b1;
        end
        prev_count = count_bcd;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        seen_09_10 = 1'b0;
        seen_99_00 = 1'b0;
        bad_nibble = 1'b0;
        prev_count = 8'h00;
        reset      = 1'b0;
        btn_run    = 1'b0;
        btn_lap    = 1'b0;
        btn_clr    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_count", count_bcd, 8'h00);
        check("rst_running", 8'(running), 8'h00);
        check("rst_sample_out", sample_out, 8'h00);
        check("rst_sample_valid", 8'(sample_valid), 8'h00);
        reset = 1'b1;
        repeat (2) step();

        // 3-cycle glitch must be rejected
        btn_run = 1'b1;
        repeat (3) step();
        btn_run = 1'b0;
        repeat (12) step();
        check("glitch_rejected", 8'(running), 8'h00);

        // Real press starts the watch
        btn_run = 1'b1;
        wait_running(1'b1, 8, "run_start");
        btn_run = 1'b0;

        // Lap at 37
        wait_count(8'h37, 500, "reach_37");
        btn_lap = 1'b1;
        exp_q.push_back(8'h37);
        repeat (8) step();
        btn_lap = 1'b0;
        repeat (8) step();

        // Wrap through 99
        wait_count(8'h00, 800, "wrap_to_00");

        // Pause at 05 with prescaler at 6
        wait_count(8'h04, 60, "reach_04");
        repeat (9) step();
        btn_run = 1'b1;
`ifdef SAMPLE_ON_PAUSE_EN
        exp_q.push_back(8'h05);
`endif
        wait_running(1'b0, 8, "pause_05");
        btn_run = 1'b0;
        repeat (50) step();
        check("paused_count", count_bcd, 8'h05);
        check("paused_running", 8'(running), 8'h00);

        // Resume: partial second kept, tick 4 cycles after resume
        btn_run = 1'b1;
        wait_running(1'b1, 8, "resume");
        check("resume_count", count_bcd, 8'h05);
        repeat (3) step();
        check("presc_kept", count_bcd, 8'h05);
        step();
        check("first_tick_after_resume", count_bcd, 8'h06);
        btn_run = 1'b0;
        repeat (8) step();

        // Clear in RUN is ignored
        btn_clr = 1'b1;
        repeat (8) step();
        btn_clr = 1'b0;
        repeat (8) step();
        check("clr_in_run_running", 8'(running), 8'h01);

        // Pause at 21
        wait_count(8'h21, 200, "reach_21");
        btn_run = 1'b1;
`ifdef SAMPLE_ON_PAUSE_EN
        exp_q.push_back(8'h21);
`endif
        wait_running(1'b0, 8, "pause_21");
        btn_run = 1'b0;
        repeat (8) step();
        check("paused_21", count_bcd, 8'h21);

        // Lap while paused
        btn_lap = 1'b1;
        exp_q.push_back(8'h21);
        repeat (8) step();
        btn_lap = 1'b0;
        repeat (8) step();

        // Clear in PAUSE returns to IDLE
        btn_clr = 1'b1;
        repeat (8) step();
        btn_clr = 1'b0;
        repeat (8) step();
        check("clr_count", count_bcd, 8'h00);
        check("clr_running", 8'(running), 8'h00);

        // Lap in IDLE is ignored
        btn_lap = 1'b1;
        repeat (8) step();
        btn_lap = 1'b0;
        repeat (8) step();

        // Prescaler cleared: first tick a full second after restart
        btn_run = 1'b1;
        wait_running(1'b1, 8, "restart");
        repeat (9) step();
        check("presc_cleared_hold", count_bcd, 8'h00);
        step();
        check("presc_cleared_tick", count_bcd, 8'h01);
        btn_run = 1'b0;
        repeat (8) step();

        // Run and clear together in PAUSE: run wins
        wait_count(8'h03, 60, "reach_03");
        btn_run = 1'b1;
`ifdef SAMPLE_ON_PAUSE_EN
        exp_q.push_back(8'h03);
`endif
        wait_running(1'b0, 8, "pause_03");
        btn_run = 1'b0;
        repeat (8) step();
        btn_run = 1'b1;
        btn_clr = 1'b1;
        wait_running(1'b1, 8, "run_beats_clr");
        check("clr_ignored_count", count_bcd, 8'h03);
        btn_run = 1'b0;
        btn_clr = 1'b0;
        repeat (8) step();

        // Asynchronous reset mid-count at 42
        wait_count(8'h42, 500, "reach_42");
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_count", count_bcd, 8'h00);
        check("async_rst_running", 8'(running), 8'h00);
        check("async_rst_sample_out", sample_out, 8'h00);
        check("async_rst_sample_valid", 8'(sample_valid), 8'h00);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (20) step();
        check("post_rst_idle_running", 8'(running), 8'h00);
        check("post_rst_idle_count", count_bcd, 8'h00);

        repeat (4) step();
        check("samples_outstanding", 8'(exp_q.size()), 8'h00);
        check("seen_09_to_10", 8'(seen_09_10), 8'h01);
        check("seen_99_to_00", 8'(seen_99_00), 8'h01);
        check("bcd_nibbles_legal", 8'(bad_nibble), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_sampler.md
# stopwatch_sampler

Front-end stage of the stopwatch datapath: debounces three raw push-buttons, runs a two-digit BCD seconds counter, and emits lap samples. Each lap press produces a one-cycle `sample_valid` pulse carrying the current BCD count. These outputs drive the downstream sample stash's `sample_in` and `sample_in_valid` inputs directly. The live count is also exported for the display path.

## Interface
- `TICK_CYCLES`, 100_000_000: clk cycles per counted second; minimum 2.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable synchronized cycles before a button level is accepted; minimum 1.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset. Asserted at 0 and takes effect immediately; deasserts to 1.
- `btn_run`  in  1  raw start/stop button, asynchronous, active-high.
- `btn_lap`  in  1  raw lap button, asynchronous, active-high.
- `btn_clr`  in  1  raw clear button, asynchronous, active-high.
- `count_bcd`  out  8  live count; [7:4] tens digit, [3:0] units digit, range 00–99 BCD.
- `running`  out  1  high while in RUN.
- `sample_out`  out  8  BCD count captured at the lap event. Holds its value between events.
- `sample_valid`  out  1  one-cycle strobe; `sample_out` is valid in the same cycle.

## Operation
- Button front end, identical for each button:
  - 2-flop synchronizer, then debouncer holding an accepted level (reset 0) and a stability counter.
  - The counter clears whenever the synchronized value equals the accepted level.
  - Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES`, the accepted level flips and the counter clears.
  - A press event is a one-cycle pulse on a 0→1 transition of the accepted level. Releases generate no event.
- State machine, states IDLE / RUN / PAUSE; reset state IDLE:
  - IDLE + run press → RUN.
  - RUN + run press → PAUSE.
  - PAUSE + run press → RUN.
  - PAUSE + clr press → IDLE: count and prescaler cleared to 0.
  - clr press in RUN or IDLE: ignored.
  - run and clr presses in the same cycle while in PAUSE: run wins (→ RUN), clr ignored.
- Prescaler counts 0..`TICK_CYCLES`-1 in RUN only.
  - It holds its value in PAUSE, so the partial second is preserved across pause.
  - It is cleared in IDLE.
  - Terminal value while in RUN produces a tick and the prescaler wraps to 0.
- On a tick the count advances as BCD:
  - Units 9 → 0 with carry into tens.
  - 99 → 00 wraps silently, no flag.
  - No nibble ever holds A–F.
- Lap press in RUN or PAUSE:
  - Next cycle: `sample_out` = `count_bcd` as registered in the press cycle, and `sample_valid` = 1 for exactly one cycle.
  - If a tick occurs in the press cycle, the pre-increment value is sampled.
  - Lap press in IDLE is ignored.
- Lap press and run press in the same cycle: the sample is taken *and* the state transition happens.
- Reset assertion at any time, including mid-debounce or mid-second:
  - All outputs go to 0 immediately: `count_bcd`=00, `running`=0, `sample_out`=00, `sample_valid`=0.
  - State returns to IDLE; synchronizers, debouncers and prescaler clear.

## Timing
- Raw button edge to press event: 2 synchronizer cycles + `DEBOUNCE_CYCLES` cycles, ±1 cycle for asynchronous input alignment.
- Press event to state/`running` change: 1 cycle (registered).
- Press event to `sample_valid`: 1 cycle.
- Tick to `count_bcd` update: 1 cycle; exactly one increment per `TICK_CYCLES` cycles spent in RUN.
- There is no backpressure. The downstream stage must accept any `sample_valid` pulse.
- Minimum spacing between two samples is 2·`DEBOUNCE_CYCLES` cycles, because a press requires a release first.

## Configuration
- `SAMPLE_ON_PAUSE_EN`:
  - When defined, the RUN → PAUSE transition also emits a sample. `sample_out` = the count at the run press and `sample_valid` pulses 1 cycle later, with the same timing as a lap.
  - If a lap press coincides with that run press, exactly one pulse is emitted.
  - When undefined, pausing emits nothing and samples come only from lap presses.

## Test plan
All scenarios use `TICK_CYCLES`=10 and `DEBOUNCE_CYCLES`=4.
- Glitch rejection: pulse `btn_run` high for 3 cycles, then low → no state change, `running` stays 0. Hold high for 8 cycles → `running`=1 within 2+4+2 cycles of the edge.
- Counting and wrap: RUN for 1000 cycles from 00 → `count_bcd`=8'h00 after wrapping through 8'h99. Observe 8'h09 → 8'h10 and 8'h99 → 8'h00 transitions, with no non-BCD nibble at any point.
- Lap: RUN until `count_bcd`=8'h37, then press lap → one `sample_valid` pulse with `sample_out`=8'h37. Counting continues unaffected.
- Pause/resume/clear:
  - Pause at 8'h05 with prescaler at 6, wait 50 cycles → count stays 8'h05.
  - Resume → next tick after 4 cycles.
  - Pause again, press clr → IDLE, `count_bcd`=8'h00.
  - clr pressed in RUN → ignored.
- Lap in IDLE → no `sample_valid` pulse. Reset pulled low mid-count at 8'h42 → all outputs 0 immediately, state IDLE.
- With `SAMPLE_ON_PAUSE_EN` defined: pause at 8'h21 → `sample_valid` pulse with `sample_out`=8'h21. Undefined → no pulse.
